// File: rtl/display_bcd_ctrl.sv
// Sequential binary-to-BCD controller for a two-digit 7-segment display.
// Converts by repeated subtraction of 10, one step per clock; digits hold until completion.
module display_bcd_ctrl #(
  parameter int LARGURA    = 8,
  parameter int MAX_VAL    = 99,
  parameter int APAGA_ZERO = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] valor,
  input  logic               carregar,
  output logic [3:0]         dezena,
  output logic [3:0]         unidade,
  output logic               ocupado,
  output logic               pronto,
  output logic               erro
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [LARGURA-1:0] MAX_V = LARGURA'(MAX_VAL);
  localparam logic [LARGURA-1:0] DEZ   = LARGURA'(10);
  localparam logic [3:0]         BLANK = 4'hF;

  state_t             state_q, state_d;
  logic [LARGURA-1:0] resto_q, resto_d;
  logic [3:0]         dez_cnt_q, dez_cnt_d;
  logic [3:0]         dezena_q, dezena_d;
  logic [3:0]         unidade_q, unidade_d;
  logic               pronto_q, pronto_d;
  logic               erro_q, erro_d;

  always_comb begin
    state_d   = state_q;
    resto_d   = resto_q;
    dez_cnt_d = dez_cnt_q;
    dezena_d  = dezena_q;
    unidade_d = unidade_q;
    erro_d    = erro_q;
    pronto_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (carregar) begin
          if (valor > MAX_V) begin
            dezena_d  = BLANK;
            unidade_d = BLANK;
            erro_d    = 1'b1;
            pronto_d  = 1'b1;
          end else begin
            resto_d   = valor;
            dez_cnt_d = '0;
            state_d   = CONV;
          end
        end
      end
      CONV: begin
        // Guarded subtraction keeps resto from wrapping; dez_cnt tops out at 9.
        if (resto_q >= DEZ) begin
          resto_d   = resto_q - DEZ;
          dez_cnt_d = dez_cnt_q + 4'd1;
        end else begin
          unidade_d = resto_q[3:0];
          dezena_d  = ((APAGA_ZERO != 0) && (dez_cnt_q == 4'd0)) ? BLANK : dez_cnt_q;
          erro_d    = 1'b0;
          pronto_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      resto_q   <= '0;
      dez_cnt_q <= '0;
      dezena_q  <= BLANK;
      unidade_q <= BLANK;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      resto_q   <= resto_d;
      dez_cnt_q <= dez_cnt_d;
      dezena_q  <= dezena_d;
      unidade_q <= unidade_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
    end
  end

  assign dezena  = dezena_q;
  assign unidade = unidade_q;
  assign ocupado = (state_q == CONV);
  assign pronto  = pronto_q;
  assign erro    = erro_q;

endmodule

// File: tb/tb_display_bcd_ctrl.sv
// Directed bench for display_bcd_ctrl; a second instance exercises leading-zero blanking.
module tb_display_bcd_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] valor = '0;
  logic       carregar = 1'b0;

  logic [3:0] dezena0, unidade0, dezena1, unidade1;
  logic       ocupado0, pronto0, erro0, ocupado1, pronto1, erro1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  display_bcd_ctrl #(.LARGURA(8), .MAX_VAL(99), .APAGA_ZERO(0)) dut0 (
    .clock(clock), .reset(reset), .valor(valor), .carregar(carregar),
    .dezena(dezena0), .unidade(unidade0), .ocupado(ocupado0),
    .pronto(pronto0), .erro(erro0)
  );

  display_bcd_ctrl #(.LARGURA(8), .MAX_VAL(99), .APAGA_ZERO(1)) dut1 (
    .clock(clock), .reset(reset), .valor(valor), .carregar(carregar),
    .dezena(dezena1), .unidade(unidade1), .ocupado(ocupado1),
    .pronto(pronto1), .erro(erro1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Load v, then expect busy for lat cycles with digits held at prev, then one pronto pulse.
  // inj >= 0 pulses carregar (valor=12) on that busy cycle to prove it is ignored.
  task automatic load_conv(input string tag, input logic [7:0] v, input int lat,
                           input logic [3:0] pd, input logic [3:0] pu,
                           input logic [3:0] ed, input logic [3:0] eu, input int inj);
    valor = v;
    carregar = 1'b1;
    step(1);
    carregar = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (i == inj) begin
        carregar = 1'b1;
        valor = 8'd12;
      end else begin
        carregar = 1'b0;
      end
      chk({tag, ".busy"}, ocupado0, 1);
      chk({tag, ".nopronto"}, pronto0, 0);
      chk({tag, ".holdd"}, dezena0, pd);
      chk({tag, ".holdu"}, unidade0, pu);
      step(1);
    end
    carregar = 1'b0;
    chk({tag, ".pronto"}, pronto0, 1);
    chk({tag, ".idle"}, ocupado0, 0);
    chk({tag, ".dezena"}, dezena0, ed);
    chk({tag, ".unidade"}, unidade0, eu);
    chk({tag, ".erro"}, erro0, 0);
    step(1);
    chk({tag, ".pulse1"}, pronto0, 0);
    chk({tag, ".hold_after"}, dezena0, ed);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("rst.dezena", dezena0, 4'hF);
    chk("rst.unidade", unidade0, 4'hF);
    chk("rst.ocupado", ocupado0, 0);
    chk("rst.pronto", pronto0, 0);
    chk("rst.erro", erro0, 0);
    chk("rst.dezena1", dezena1, 4'hF);

    load_conv("v47", 8'd47, 5, 4'hF, 4'hF, 4'd4, 4'd7, -1);

    load_conv("v0", 8'd0, 1, 4'd4, 4'd7, 4'd0, 4'd0, -1);
    chk("v0.blank.dezena", dezena1, 4'hF);
    chk("v0.blank.unidade", unidade1, 4'd0);

    load_conv("v99", 8'd99, 10, 4'd0, 4'd0, 4'd9, 4'd9, -1);
    chk("v99.blank_nz.dezena", dezena1, 4'd9);

    // Out of range: one-cycle result, no CONV
    valor = 8'd150;
    carregar = 1'b1;
    step(1);
    carregar = 1'b0;
    chk("v150.dezena", dezena0, 4'hF);
    chk("v150.unidade", unidade0, 4'hF);
    chk("v150.erro", erro0, 1);
    chk("v150.pronto", pronto0, 1);
    chk("v150.ocupado", ocupado0, 0);
    step(1);
    chk("v150.pulse1", pronto0, 0);
    chk("v150.erro_hold", erro0, 1);

    // Boundary just over MAX_VAL
    valor = 8'd100;
    carregar = 1'b1;
    step(1);
    carregar = 1'b0;
    chk("v100.erro", erro0, 1);
    chk("v100.ocupado", ocupado0, 0);
    step(1);

    load_conv("v5", 8'd5, 1, 4'hF, 4'hF, 4'd0, 4'd5, -1);

    load_conv("v83", 8'd83, 9, 4'd0, 4'd5, 4'd8, 4'd3, 2);

    // Reset on the 4th CONV cycle of a 99 conversion
    valor = 8'd99;
    carregar = 1'b1;
    step(1);
    carregar = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst.dezena", dezena0, 4'hF);
    chk("midrst.unidade", unidade0, 4'hF);
    chk("midrst.ocupado", ocupado0, 0);
    chk("midrst.pronto", pronto0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("midrst.nopronto", pronto0, 0);
      step(1);
    end

    load_conv("v21", 8'd21, 3, 4'hF, 4'hF, 4'd2, 4'd1, -1);

    // Reset and load in the same cycle: reset wins
    reset = 1'b1;
    valor = 8'd30;
    carregar = 1'b1;
    step(1);
    reset = 1'b0;
    carregar = 1'b0;
    chk("rstload.ocupado", ocupado0, 0);
    chk("rstload.dezena", dezena0, 4'hF);
    step(1);
    chk("rstload.still_idle", ocupado0, 0);

    // carregar held high: reload on the cycle after completion
    valor = 8'd12;
    carregar = 1'b1;
    step(1);
    chk("hold.busy_k", ocupado0, 1);
    step(1);
    chk("hold.busy_k1", ocupado0, 1);
    step(1);
    chk("hold.pronto", pronto0, 1);
    chk("hold.idle", ocupado0, 0);
    chk("hold.dezena", dezena0, 4'd1);
    chk("hold.unidade", unidade0, 4'd2);
    step(1);
    carregar = 1'b0;
    chk("hold.reload", ocupado0, 1);
    chk("hold.reload_np", pronto0, 0);
    step(2);
    chk("hold.pronto2", pronto0, 1);
    step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
